// File: rtl/ascii_to_scancode.sv
// Converts one accepted ASCII byte into its AT set-2 make/break byte stream,
// offering each byte with a strobe held until the downstream transmitter acks it.
module ascii_to_scancode #(
  parameter int GAP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ascii,
  input  logic       strobe_in,
  output logic       busy,
  output logic [7:0] scancode,
  output logic       strobe_out,
  input  logic       ack_in,
  output logic       unsupported,
  output logic [3:0] state_dbg
);
  // Handshake: a byte is transferred on a rising edge where strobe_out=1 and
  // ack_in=1; strobe_out and scancode stay stable until then, and ack_in is
  // ignored whenever strobe_out=0.
  typedef enum logic [3:0] {
    IDLE, LOOKUP, MOD_MAKE, KEY_MAKE, KEY_PFX, KEY_BRK, MOD_PFX, MOD_BRK, GAP
  } state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state_q, state_d, target_q, target_d, after_s;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      ascii_q, scancode_q, next_code;
  logic [7:0]      lk_code, punct_code, mod_code;
  logic            lk_valid, lk_shift, lk_ctrl, need_mod;
  logic [4:0]      letter_idx;

  function automatic logic [7:0] letter_code(input logic [4:0] idx);
    case (idx)
      5'd0:  return 8'h1C;  5'd1:  return 8'h32;  5'd2:  return 8'h21;
      5'd3:  return 8'h23;  5'd4:  return 8'h24;  5'd5:  return 8'h2B;
      5'd6:  return 8'h34;  5'd7:  return 8'h33;  5'd8:  return 8'h43;
      5'd9:  return 8'h3B;  5'd10: return 8'h42;  5'd11: return 8'h4B;
      5'd12: return 8'h3A;  5'd13: return 8'h31;  5'd14: return 8'h44;
      5'd15: return 8'h4D;  5'd16: return 8'h15;  5'd17: return 8'h2D;
      5'd18: return 8'h1B;  5'd19: return 8'h2C;  5'd20: return 8'h3C;
      5'd21: return 8'h2A;  5'd22: return 8'h1D;  5'd23: return 8'h22;
      5'd24: return 8'h35;  5'd25: return 8'h1A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0: return 8'h45;  4'd1: return 8'h16;  4'd2: return 8'h1E;
      4'd3: return 8'h26;  4'd4: return 8'h25;  4'd5: return 8'h2E;
      4'd6: return 8'h36;  4'd7: return 8'h3D;  4'd8: return 8'h3E;
      4'd9: return 8'h46;
      default: return 8'h00;
    endcase
  endfunction

  // Shifted US punctuation; 00 means "not a shifted punctuation character".
  function automatic logic [7:0] shifted_punct(input logic [7:0] ch);
    case (ch)
      8'h21: return 8'h16;  8'h40: return 8'h1E;  8'h23: return 8'h26;
      8'h24: return 8'h25;  8'h25: return 8'h2E;  8'h5E: return 8'h36;
      8'h26: return 8'h3D;  8'h2A: return 8'h3E;  8'h28: return 8'h46;
      8'h29: return 8'h45;  8'h5F: return 8'h4E;  8'h2B: return 8'h55;
      8'h7B: return 8'h54;  8'h7D: return 8'h5B;  8'h7C: return 8'h5D;
      8'h3A: return 8'h4C;  8'h22: return 8'h52;  8'h3C: return 8'h41;
      8'h3E: return 8'h49;  8'h3F: return 8'h4A;  8'h7E: return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  // Letters, their upper-case forms and ctrl bytes 01-1A all share one index.
  assign letter_idx = ascii_q[4:0] - 5'd1;
  assign punct_code = shifted_punct(ascii_q);

  always_comb begin
    lk_valid = 1'b0;
    lk_shift = 1'b0;
    lk_ctrl  = 1'b0;
    lk_code  = 8'h00;
    if (ascii_q >= 8'h61 && ascii_q <= 8'h7A) begin
      lk_valid = 1'b1;
      lk_code  = letter_code(letter_idx);
    end else if (ascii_q >= 8'h41 && ascii_q <= 8'h5A) begin
      lk_valid = 1'b1;
      lk_shift = 1'b1;
      lk_code  = letter_code(letter_idx);
    end else if (ascii_q >= 8'h30 && ascii_q <= 8'h39) begin
      lk_valid = 1'b1;
      lk_code  = digit_code(ascii_q[3:0]);
    end else if (punct_code != 8'h00) begin
      lk_valid = 1'b1;
      lk_shift = 1'b1;
      lk_code  = punct_code;
    end else begin
      lk_valid = 1'b1;
      case (ascii_q)
        8'h20: lk_code = 8'h29;
        8'h0D: lk_code = 8'h5A;
        8'h08: lk_code = 8'h66;
        8'h09: lk_code = 8'h0D;
        8'h1B: lk_code = 8'h76;
        default: begin
          if (ascii_q >= 8'h01 && ascii_q <= 8'h1A) begin
            lk_ctrl = 1'b1;
            lk_code = letter_code(letter_idx);
          end else begin
            lk_valid = 1'b0;
          end
        end
      endcase
    end
  end

  assign need_mod = lk_shift | lk_ctrl;
  assign mod_code = lk_ctrl ? 8'h14 : 8'h12;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    gap_d    = gap_q;
    after_s  = IDLE;
    case (state_q)
      IDLE:   if (strobe_in) state_d = LOOKUP;
      LOOKUP: begin
        if (!lk_valid)     state_d = IDLE;
        else if (need_mod) state_d = MOD_MAKE;
        else               state_d = KEY_MAKE;
      end
      MOD_MAKE, KEY_MAKE, KEY_PFX, KEY_BRK, MOD_PFX, MOD_BRK: begin
        case (state_q)
          MOD_MAKE: after_s = KEY_MAKE;
          KEY_MAKE: after_s = KEY_PFX;
          KEY_PFX:  after_s = KEY_BRK;
          KEY_BRK:  after_s = need_mod ? MOD_PFX : IDLE;
          MOD_PFX:  after_s = MOD_BRK;
          default:  after_s = IDLE;
        endcase
        if (ack_in) begin
          if (GAP_CYCLES == 0) begin
            state_d = after_s;
          end else begin
            state_d  = GAP;
            target_d = after_s;
            gap_d    = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = target_q;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The byte register only loads on entry to an emit state, so it holds
  // its last value through gaps and idle.
  always_comb begin
    next_code = scancode_q;
    case (state_d)
      MOD_MAKE, MOD_BRK: next_code = mod_code;
      KEY_MAKE, KEY_BRK: next_code = lk_code;
      KEY_PFX, MOD_PFX:  next_code = 8'hF0;
      default:           next_code = scancode_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      target_q   <= IDLE;
      gap_q      <= '0;
      ascii_q    <= 8'h00;
      scancode_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      gap_q      <= gap_d;
      scancode_q <= next_code;
      if (state_q == IDLE && strobe_in) ascii_q <= ascii;
    end
  end

  assign busy        = (state_q != IDLE);
  assign strobe_out  = (state_q == MOD_MAKE) || (state_q == KEY_MAKE) ||
                       (state_q == KEY_PFX)  || (state_q == KEY_BRK)  ||
                       (state_q == MOD_PFX)  || (state_q == MOD_BRK);
  assign unsupported = (state_q == LOOKUP) && !lk_valid;
  assign scancode    = scancode_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_ascii_to_scancode.sv
// Bench for ascii_to_scancode: a table-driven US set-2 model builds the expected
// byte stream per character; a second instance covers the zero-gap case.
module tb_ascii_to_scancode;
  localparam int GAP = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ascii = 8'h00;
  logic       strobe_in = 1'b0, ack_in = 1'b0;
  logic       busy, strobe_out, unsupported;
  logic [7:0] scancode;
  logic [3:0] state_dbg;

  logic [7:0] z_ascii = 8'h00;
  logic       z_strobe_in = 1'b0, z_ack_in = 1'b0;
  logic       z_busy, z_strobe_out, z_unsupported;
  logic [7:0] z_scancode;
  logic [3:0] z_state_dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [7:0] letter_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] punct_chr [21] = '{"!", "@", "#", "$", "%", "^", "&", "*", "(", ")",
    "_", "+", "{", "}", "|", ":", 8'h22, "<", ">", "?", "~"};
  logic [7:0] punct_code [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
    8'h49, 8'h4A, 8'h0E};

  ascii_to_scancode #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .reset(reset), .ascii(ascii), .strobe_in(strobe_in),
    .busy(busy), .scancode(scancode), .strobe_out(strobe_out), .ack_in(ack_in),
    .unsupported(unsupported), .state_dbg(state_dbg));

  ascii_to_scancode #(.GAP_CYCLES(0)) dut_z (
    .clock(clock), .reset(reset), .ascii(z_ascii), .strobe_in(z_strobe_in),
    .busy(z_busy), .scancode(z_scancode), .strobe_out(z_strobe_out), .ack_in(z_ack_in),
    .unsupported(z_unsupported), .state_dbg(z_state_dbg));

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: byte list for one character, empty when unsupported.
  function automatic void build_expect(input logic [7:0] ch);
    logic [7:0] key;
    bit ok, sh, ct;
    ok = 0; sh = 0; ct = 0; key = 8'h00;
    exp_q.delete();
    if (ch >= "a" && ch <= "z") begin ok = 1; key = letter_tab[ch - 8'h61]; end
    else if (ch >= "A" && ch <= "Z") begin ok = 1; sh = 1; key = letter_tab[ch - 8'h41]; end
    else if (ch >= "0" && ch <= "9") begin ok = 1; key = digit_tab[ch - 8'h30]; end
    else if (ch == 8'h20) begin ok = 1; key = 8'h29; end
    else if (ch == 8'h0D) begin ok = 1; key = 8'h5A; end
    else if (ch == 8'h08) begin ok = 1; key = 8'h66; end
    else if (ch == 8'h09) begin ok = 1; key = 8'h0D; end
    else if (ch == 8'h1B) begin ok = 1; key = 8'h76; end
    else if (ch >= 8'h01 && ch <= 8'h1A) begin ok = 1; ct = 1; key = letter_tab[ch - 8'h01]; end
    else begin
      for (int i = 0; i < 21; i++)
        if (punct_chr[i] == ch) begin ok = 1; sh = 1; key = punct_code[i]; end
    end
    if (!ok) return;
    if (ct) exp_q.push_back(8'h14);
    else if (sh) exp_q.push_back(8'h12);
    exp_q.push_back(key);
    exp_q.push_back(8'hF0);
    exp_q.push_back(key);
    if (ct || sh) begin
      exp_q.push_back(8'hF0);
      exp_q.push_back(ct ? 8'h14 : 8'h12);
    end
  endfunction

  // Sends one character, acks each byte after ack_delay cycles, and checks
  // bytes, gap lengths, hold stability and the busy tail. poke raises a second
  // strobe_in during the sequence, which must be ignored.
  task automatic run_char(input logic [7:0] ch, input int ack_delay, input bit poke);
    int gap_seen, tail, guard;
    bit first;
    logic [7:0] held, exp_b;
    build_expect(ch);
    @(negedge clock);
    ack_in = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_before ch=%h busy=%b want 0", ch, busy); end
    ascii = ch; strobe_in = 1'b1;
    @(negedge clock);
    strobe_in = 1'b0;
    ascii = 8'($urandom_range(0, 255));
    ack_in = 1'($urandom_range(0, 1));
    checks++;
    if (busy !== 1'b1 || strobe_out !== 1'b0) begin
      errors++; $display("FAIL lookup ch=%h busy=%b strobe_out=%b want 1/0", ch, busy, strobe_out);
    end
    checks++;
    if (unsupported !== (exp_q.size() == 0)) begin
      errors++; $display("FAIL unsupported ch=%h got %b want %b", ch, unsupported, exp_q.size() == 0);
    end
    if (exp_q.size() == 0) begin
      @(negedge clock);
      ack_in = 1'b0;
      checks++;
      if (busy !== 1'b0 || unsupported !== 1'b0 || strobe_out !== 1'b0) begin
        errors++; $display("FAIL invalid_end ch=%h busy=%b unsup=%b strobe_out=%b want 0/0/0",
                           ch, busy, unsupported, strobe_out);
      end
      return;
    end
    first = 1; gap_seen = 0; guard = 0; held = 8'h00;
    while (exp_q.size() > 0 && guard < 300) begin
      @(negedge clock);
      ack_in = 1'b0; strobe_in = 1'b0; guard++;
      if (strobe_out !== 1'b1) begin
        gap_seen++;
        ack_in = 1'($urandom_range(0, 1));
        if (!first) begin
          checks++;
          if (scancode !== held) begin errors++; $display("FAIL gap_hold got %h want %h", scancode, held); end
        end
        continue;
      end
      exp_b = exp_q.pop_front();
      checks++;
      if (gap_seen != (first ? 0 : GAP)) begin
        errors++; $display("FAIL gap_len ch=%h got %0d want %0d", ch, gap_seen, first ? 0 : GAP);
      end
      checks++;
      if (scancode !== exp_b) begin errors++; $display("FAIL byte ch=%h got %h want %h", ch, scancode, exp_b); end
      held = scancode;
      if (first && poke) begin ascii = 8'h5A; strobe_in = 1'b1; end
      first = 0; gap_seen = 0;
      repeat (ack_delay) begin
        @(negedge clock);
        strobe_in = 1'b0;
        checks++;
        if (strobe_out !== 1'b1 || scancode !== held) begin
          errors++; $display("FAIL hold strobe_out=%b scancode=%h want 1/%h", strobe_out, scancode, held);
        end
      end
      ack_in = 1'b1;
    end
    checks++;
    if (guard >= 300) begin errors++; $display("FAIL timeout ch=%h bytes_left=%0d want 0", ch, exp_q.size()); end
    tail = 0;
    while (tail < 50) begin
      @(negedge clock);
      ack_in = 1'b0;
      if (strobe_out === 1'b1) begin
        checks++; errors++; $display("FAIL extra_byte ch=%h got %h want none", ch, scancode);
        ack_in = 1'b1;
      end
      if (busy !== 1'b1) break;
      tail++;
    end
    checks++;
    if (tail != GAP) begin errors++; $display("FAIL busy_tail ch=%h got %0d want %0d", ch, tail, GAP); end
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || strobe_out !== 1'b0) begin
        errors++; $display("FAIL quiet_after ch=%h busy=%b strobe_out=%b want 0/0", ch, busy, strobe_out);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; strobe_in = 1'b1; ack_in = 1'b1; ascii = 8'h61;
    z_strobe_in = 1'b1; z_ack_in = 1'b1; z_ascii = 8'h41;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || strobe_out !== 1'b0 || unsupported !== 1'b0 || scancode !== 8'h00 ||
          z_busy !== 1'b0 || z_strobe_out !== 1'b0 || z_scancode !== 8'h00) begin
        errors++; $display("FAIL reset_state busy=%b so=%b un=%b sc=%h zbusy=%b zso=%b zsc=%h want zeros",
                           busy, strobe_out, unsupported, scancode, z_busy, z_strobe_out, z_scancode);
      end
    end
    strobe_in = 1'b0; ack_in = 1'b0; z_strobe_in = 1'b0; z_ack_in = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_char(8'h61, 1, 0);
    run_char(8'h41, 0, 0);
    run_char(8'h03, 1, 0);
    run_char(8'h0D, 2, 0);
    run_char(8'h80, 0, 0);
    run_char(8'h00, 0, 0);
  endtask

  task automatic test_ignore_busy();
    run_char(8'h62, 1, 1);
    run_char(8'h24, 0, 1);
  endtask

  task automatic test_ack_withheld();
    run_char(8'h61, 20, 0);
  endtask

  task automatic test_reset_mid();
    int guard;
    @(negedge clock);
    ascii = 8'h41; strobe_in = 1'b1;
    @(negedge clock);
    strobe_in = 1'b0;
    @(negedge clock);
    checks++;
    if (strobe_out !== 1'b1 || scancode !== 8'h12) begin
      errors++; $display("FAIL mid_first so=%b sc=%h want 1/12", strobe_out, scancode);
    end
    ack_in = 1'b1;
    guard = 0;
    do begin @(negedge clock); ack_in = 1'b0; guard++; end while (strobe_out !== 1'b1 && guard < 50);
    reset = 1'b1; ack_in = 1'b1; strobe_in = 1'b1; ascii = 8'h41;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || strobe_out !== 1'b0 || unsupported !== 1'b0 || scancode !== 8'h00) begin
        errors++; $display("FAIL mid_reset busy=%b so=%b un=%b sc=%h want 0/0/0/00",
                           busy, strobe_out, unsupported, scancode);
      end
    end
    reset = 1'b0; ack_in = 1'b0; strobe_in = 1'b0;
    repeat (10) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || strobe_out !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet busy=%b so=%b want 0/0", busy, strobe_out);
      end
    end
    run_char(8'h61, 1, 0);
  endtask

  task automatic test_gap0(input logic [7:0] ch);
    logic [7:0] exp_b;
    build_expect(ch);
    @(negedge clock);
    z_ascii = ch; z_strobe_in = 1'b1; z_ack_in = 1'b1;
    @(negedge clock);
    z_strobe_in = 1'b0;
    checks++;
    if (z_busy !== 1'b1 || z_strobe_out !== 1'b0) begin
      errors++; $display("FAIL gap0_lookup busy=%b so=%b want 1/0", z_busy, z_strobe_out);
    end
    while (exp_q.size() > 0) begin
      exp_b = exp_q.pop_front();
      @(negedge clock);
      checks++;
      if (z_strobe_out !== 1'b1 || z_scancode !== exp_b) begin
        errors++; $display("FAIL gap0_byte ch=%h so=%b got %h want %h", ch, z_strobe_out, z_scancode, exp_b);
      end
    end
    @(negedge clock);
    z_ack_in = 1'b0;
    checks++;
    if (z_busy !== 1'b0 || z_strobe_out !== 1'b0) begin
      errors++; $display("FAIL gap0_end busy=%b so=%b want 0/0", z_busy, z_strobe_out);
    end
  endtask

  task automatic test_random(input int n);
    logic [7:0] ch;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 6))
        0: ch = 8'($urandom_range(8'h61, 8'h7A));
        1: ch = 8'($urandom_range(8'h41, 8'h5A));
        2: ch = 8'($urandom_range(8'h30, 8'h39));
        3: ch = 8'($urandom_range(8'h01, 8'h1B));
        4: ch = punct_chr[$urandom_range(0, 20)];
        5: ch = 8'($urandom_range(8'h80, 8'hFF));
        default: ch = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'($urandom_range(8'h1C, 8'h1F));
      endcase
      run_char(ch, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_busy();
    test_ack_withheld();
    test_reset_mid();
    test_gap0(8'h61);
    test_gap0(8'h41);
    test_gap0(8'h03);
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ascii_to_scancode.md
ASCII_TO_SCANCODE -- requirements
Module: ascii_to_scancode

Interface
REQ-001 Parameter GAP_CYCLES, default 4, idle cycles inserted after each accepted scancode byte before the next byte is presented.
REQ-002 Port clock  input  1  single clock; all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port ascii  input  8  character to send; sampled only on acceptance.
REQ-005 Port strobe_in  input  1  one-cycle-or-longer request; accepted when high and busy low.
REQ-006 Port busy  output  1  high from the cycle after acceptance until the sequence completes.
REQ-007 Port scancode  output  8  AT set-2 byte being offered downstream.
REQ-008 Port strobe_out  output  1  scancode valid; held until ack_in.
REQ-009 Port ack_in  input  1  downstream (PS/2 transmitter) has taken scancode.
REQ-010 Port unsupported  output  1  one-cycle pulse when an accepted character has no mapping.

Function
REQ-011 Acceptance SHALL occur on a cycle with strobe_in=1 and busy=0; ascii is latched; strobe_in while busy=1 SHALL be ignored, not queued.
REQ-012 Lookup SHALL be combinational on the latched byte, producing {valid, need_shift, need_ctrl, code[7:0]} per US set-2 layout.
REQ-013 Mapping: 'a'-'z' unshifted (e.g. a=1C, b=32, c=21, d=23); 'A'-'Z' same code with need_shift; '0'-'9' (0=45,1=16..9=46); space=29; CR 0x0D=5A; BS 0x08=66; TAB 0x09=0D; ESC 0x1B=76.
REQ-014 Remaining control bytes 0x01-0x1A SHALL map to the code of the letter (byte+0x60) with need_ctrl.
REQ-015 Shifted punctuation from the US layout SHALL map with need_shift; all other bytes, including bit 7 set, SHALL be invalid.
REQ-016 Invalid: unsupported pulses one cycle after acceptance, no strobe_out, return to IDLE; busy high for exactly that one cycle.
REQ-017 Valid sequence: [MOD] KEY, F0, KEY, [F0, MOD]; MOD=12 if need_shift, 14 if need_ctrl (ctrl wins if both).
REQ-018 States: IDLE, LOOKUP, MOD_MAKE, KEY_MAKE, KEY_PFX, KEY_BRK, MOD_PFX, MOD_BRK, GAP.
REQ-019 Transitions: IDLE->LOOKUP on accept; LOOKUP->MOD_MAKE (modifier), KEY_MAKE (plain) or IDLE (invalid).
REQ-020 Each emit state SHALL drive scancode and strobe_out=1 and hold them stable until ack_in=1, then go to GAP.
REQ-021 GAP SHALL count GAP_CYCLES cycles with strobe_out=0, then advance to the next emit state in sequence, or IDLE after the final byte.
REQ-022 ack_in while strobe_out=0 SHALL be ignored.
REQ-023 First strobe_out SHALL rise two cycles after the acceptance edge (LOOKUP then emit).
REQ-024 scancode SHALL hold its last value when strobe_out=0.
REQ-025 busy SHALL fall in the cycle the FSM re-enters IDLE; a new strobe_in SHALL be accepted that same cycle.
REQ-026 GAP_CYCLES=0 SHALL pass directly to the next emit state without an idle cycle.

Reset
REQ-027 reset=1 SHALL force IDLE, busy=0, strobe_out=0, unsupported=0, scancode=00, gap counter=0, discarding any partial sequence.
REQ-028 Reset SHALL win over ack_in and strobe_in in the same cycle; no modifier break is emitted for an aborted sequence.

Verification
REQ-029 ascii=61 ('a'), ack_in one cycle after each strobe_out -> bytes 1C, F0, 1C; busy then low.
REQ-030 ascii=41 ('A') -> 12, 1C, F0, 1C, F0, 12; GAP_CYCLES=4 idle cycles between each.
REQ-031 ascii=03 (ctrl-C) -> 14, 21, F0, 21, F0, 14; ascii=0D -> 5A, F0, 5A (no modifier).
REQ-032 ascii=80 -> unsupported pulse one cycle, no strobe_out, busy low next cycle; second strobe_in during a valid sequence -> ignored, no extra bytes.
REQ-033 ack_in withheld 20 cycles -> scancode/strobe_out stable throughout; reset asserted mid-sequence (after 12) -> all outputs 0, IDLE, next 'a' sends 1C, F0, 1C.
